data_mem_io: RTL and testbench
==============================

Name: data_mem_io

Overview:
- Memory-side responder for the single-cycle lab CPU. It receives the CPU's data address (DataA), store data (DataB) and write strobe (MW), and returns load data to the CPU's Din port.
- Holds a 128-byte data RAM and a small memory-mapped I/O window: a TX FIFO toward a slow peripheral and a one-entry RX holding register from it.
- Drives STALL to the CPU's EN_L when a store cannot complete, or while memory is being cleared.

Parameters:
- RAM_AW, 7, RAM address bits; RAM covers 0x00 to 2^RAM_AW-1.
- IO_BASE, 8'hF0, base address of the I/O registers.
- FIFO_AW, 2, TX FIFO address bits; depth is 2^FIFO_AW = 4.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- ADDR  input  8  data address, from CPU DataA.
- WDATA  input  8  store data, from CPU DataB.
- MW  input  1  store strobe from CPU.
- RDATA  output  8  load data, to CPU Din; combinational from ADDR.
- STALL  output  1  hold request, to CPU EN_L (1 = CPU holds).
- TX_DATA  output  8  head of TX FIFO.
- TX_VALID  output  1  TX FIFO not empty.
- TX_READY  input  1  peripheral accepts TX_DATA this cycle.
- RX_DATA  input  8  peripheral data.
- RX_VALID  input  1  peripheral offers RX_DATA.
- RX_READY  output  1  RX holding register empty.

Behaviour:
- Address map:
  - 0x00 to 0x7F: RAM.
  - IO_BASE+0 TXD: write-only. A store pushes to the FIFO; a read returns 0x00.
  - IO_BASE+1 STAT: read-only. {5'b0, rx_full, fifo_full, fifo_empty}.
  - IO_BASE+2 RXD: a read returns the held byte. A store of any value pops it (clears rx_full).
  - All other addresses: read 0x00; stores ignored.
- Store commit: a store is effective only on a posedge where MW=1 and STALL=0.
- Reads: combinational, zero latency. A store and a read of the same RAM address in the same cycle returns the old byte; the new byte is visible the next cycle.
- STALL:
  - Asserted combinationally when MW=1, ADDR=TXD and count==depth.
  - A pop in the same cycle does not relieve the stall: no bypass, decision based on the registered count.
  - STALL is also forced to 1 in CLEAR state (see Optional Feature).
- TX FIFO:
  - Circular buffer with FIFO_AW-bit read/write pointers that wrap modulo depth, plus a (FIFO_AW+1)-bit count.
  - TX_VALID = (count != 0); TX_DATA = mem[rptr].
  - Pop occurs when TX_VALID & TX_READY.
  - Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
  - Push while empty with TX_READY=1: the byte appears on TX_DATA the next cycle. No fall-through.
- RX:
  - RX_READY = ~rx_full.
  - On RX_VALID & RX_READY: capture RX_DATA and set rx_full.
  - A pop store to RXD and a new capture in the same cycle cannot occur, because RX_READY=0 while full. The pop takes effect and the capture happens on a later cycle.
- Reset values:
  - Pointers, count and rx_full reset to 0; the rx byte resets to 0x00.
  - Outputs after reset: TX_VALID=0, RX_READY=1, STALL=0 (feature off).
  - RAM contents are not affected by RESET when the feature is off.
- Reset dominates all same-cycle pushes, pops and captures.

Optional Feature:
- Macro: DATA_MEM_CLEAR_EN.
- Defined:
  - RESET forces state CLEAR with clr_addr=0.
  - Each cycle in CLEAR writes 0x00 to RAM[clr_addr] and increments clr_addr. After writing address 2^RAM_AW-1, the block moves to RUN on the next cycle.
  - In CLEAR: STALL=1, RDATA=0x00, CPU stores are ignored; FIFO and RX operate normally.
  - A reset mid-clear restarts the clear at address 0. The clear takes 128 cycles at the default RAM_AW.
- Undefined: no CLEAR state; the block is in RUN immediately after reset.

Decomposition:
- Package data_mem_io_pkg:
  - Address constants: ADDR_TXD, ADDR_STAT, ADDR_RXD, RAM_LIMIT.
  - STAT bit indices.
  - State encoding: RUN, CLEAR.
- Sub-module: sync_fifo, parameterised by width and FIFO_AW, with push/pop/full/empty/count ports, instantiated once for TX.

Test Plan:
- RAM: store 0x5A to 0x10, then read 0x10 -> RDATA=0x5A. Read 0x80 -> 0x00. Store to 0x90 -> no state change.
- TX fill with TX_READY=0: store 0x01 to 0x04 at 0xF0 -> STAT=0x02. A fifth store asserts STALL. Raise TX_READY -> pops in order 0x01 to 0x04; the stall releases the cycle after count<4, and the fifth byte is then accepted.
- TX wrap: with TX_READY=1, push 10 bytes back-to-back -> TX_DATA sequence is exact, with no loss across pointer wrap.
- RX: drive RX_VALID=1, RX_DATA=0xC3 -> next cycle RX_READY=0, STAT bit2=1, read 0xF2=0xC3. Store to 0xF2 -> RX_READY=1. A second byte held by the peripheral is captured afterwards.
- Reset mid-traffic: RESET with FIFO holding 3 bytes and rx_full=1 -> next cycle TX_VALID=0, RX_READY=1, STAT=0x01.
- With DATA_MEM_CLEAR_EN: write 0xFF to 0x7F, then reset -> STALL=1 for exactly 128 cycles, then 0x7F reads 0x00. Reset at clear cycle 50 -> 128 more cycles of STALL.

Source files
------------

// File: rtl/data_mem_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_io_pkg
// Description : Shared constants, STAT bit positions and state encoding for
//               the data_mem_io memory/I-O responder.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_io_pkg;

    localparam int          RAM_AW_DEF  = 7;
    localparam logic [7:0]  IO_BASE_DEF = 8'hF0;
    localparam int          FIFO_AW_DEF = 2;

    // Register offsets inside the I/O window
    localparam logic [7:0]  TXD_OFS  = 8'd0;
    localparam logic [7:0]  STAT_OFS = 8'd1;
    localparam logic [7:0]  RXD_OFS  = 8'd2;

    // Absolute addresses for the default configuration
    localparam logic [7:0]  ADDR_TXD  = IO_BASE_DEF + TXD_OFS;
    localparam logic [7:0]  ADDR_STAT = IO_BASE_DEF + STAT_OFS;
    localparam logic [7:0]  ADDR_RXD  = IO_BASE_DEF + RXD_OFS;
    localparam logic [8:0]  RAM_LIMIT = 9'(1 << RAM_AW_DEF);

    // STAT register bit positions
    localparam int          STAT_TX_EMPTY = 0;
    localparam int          STAT_TX_FULL  = 1;
    localparam int          STAT_RX_FULL  = 2;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } mem_state_e;

    function automatic logic [7:0] pack_stat(input logic rx_full,
                                             input logic tx_full,
                                             input logic tx_empty);
        logic [7:0] v;
        v                = 8'h00;
        v[STAT_RX_FULL]  = rx_full;
        v[STAT_TX_FULL]  = tx_full;
        v[STAT_TX_EMPTY] = tx_empty;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_io_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_io_if
// Description : CPU data bus plus TX/RX peripheral streams of data_mem_io.
//               slave = the responder, master = CPU and peripheral side.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_io_if;

    logic [7:0] ADDR;
    logic [7:0] WDATA;
    logic       MW;
    logic [7:0] RDATA;
    logic       STALL;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;

    modport slave (
        input  ADDR, WDATA, MW, TX_READY, RX_DATA, RX_VALID,
        output RDATA, STALL, TX_DATA, TX_VALID, RX_READY
    );

    modport master (
        output ADDR, WDATA, MW, TX_READY, RX_DATA, RX_VALID,
        input  RDATA, STALL, TX_DATA, TX_VALID, RX_READY
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_io_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock circular FIFO, 2^AW entries, registered output
//               (no fall-through). Push is ignored when full, pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic      [AW:0]      count
);

    localparam int c_depth = 1 << AW;

    logic [WIDTH-1:0] r_mem [c_depth];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (AW+1)'(c_depth));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // Storage array: written at the write pointer, never reset
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers wrap naturally modulo depth; count tracks occupancy
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_io.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_io
// Description : Data-memory responder for the single-cycle lab CPU: 2^RAM_AW
//               byte RAM, TX FIFO and one-entry RX register mapped at IO_BASE.
//               Optional macro DATA_MEM_CLEAR_EN: zero the RAM after reset,
//               stalling the CPU until the sweep completes.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int         RAM_AW  = RAM_AW_DEF,
    parameter logic [7:0] IO_BASE = IO_BASE_DEF,
    parameter int         FIFO_AW = FIFO_AW_DEF
) (
    input  wire logic     CLK,
    input  wire logic     RESET,
    data_mem_io_if.slave  bus
);

    localparam int         c_ram_depth = 1 << RAM_AW;
    localparam logic [7:0] c_addr_txd  = IO_BASE + TXD_OFS;
    localparam logic [7:0] c_addr_stat = IO_BASE + STAT_OFS;
    localparam logic [7:0] c_addr_rxd  = IO_BASE + RXD_OFS;

    logic [7:0]        r_ram [c_ram_depth];
    logic              r_rx_full;
    logic [7:0]        r_rx_data;

    logic              w_is_ram;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_clearing;
    logic [RAM_AW-1:0] w_clr_addr;
    logic              w_stall;
    logic              w_commit;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [7:0]        w_tx_dout;
    logic [FIFO_AW:0]  w_tx_count;
    logic              w_rx_pop;
    logic              w_rx_capture;

    assign w_is_ram  = ({1'b0, bus.ADDR} < 9'(c_ram_depth));
    assign w_ram_idx = bus.ADDR[RAM_AW-1:0];

`ifdef DATA_MEM_CLEAR_EN
    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [RAM_AW-1:0] r_clr_addr;

    // Clear-sweep state register; reset always restarts the sweep at 0
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    // Leave CLEAR once the last RAM address has been written
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == CLEAR && r_clr_addr == '1) begin
            w_state_nxt = RUN;
        end
    end

    assign w_clearing = (r_state == CLEAR);
    assign w_clr_addr = r_clr_addr;
`else
    assign w_clearing = 1'b0;
    assign w_clr_addr = '0;
`endif

    // Stall decision uses the registered FIFO count only; a same-cycle pop
    // does not open a slot for the store.
    assign w_stall   = w_clearing |
                       (bus.MW & (bus.ADDR == c_addr_txd) & w_tx_full);
    assign w_commit  = bus.MW & ~w_stall;
    assign w_tx_push = w_commit & (bus.ADDR == c_addr_txd);
    assign w_tx_pop  = ~w_tx_empty & bus.TX_READY;
    assign w_rx_pop     = w_commit & (bus.ADDR == c_addr_rxd);
    assign w_rx_capture = bus.RX_VALID & ~r_rx_full;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_tx_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (w_tx_push),
        .din   (bus.WDATA),
        .pop   (w_tx_pop),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    // RAM write port: clear sweep has priority over (already stalled) stores
    always_ff @(posedge CLK) begin
        if (w_clearing) begin
            r_ram[w_clr_addr] <= 8'h00;
        end else if (w_commit && w_is_ram) begin
            r_ram[w_ram_idx] <= bus.WDATA;
        end
    end

    // RX holding register: capture when empty, emptied by a store to RXD
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rx_full <= 1'b0;
            r_rx_data <= 8'h00;
        end else if (w_rx_capture) begin
            r_rx_full <= 1'b1;
            r_rx_data <= bus.RX_DATA;
        end else if (w_rx_pop) begin
            r_rx_full <= 1'b0;
        end
    end

    // Zero-latency read mux over RAM and the I/O window
    always_comb begin
        bus.RDATA = 8'h00;
        if (w_clearing) begin
            bus.RDATA = 8'h00;
        end else if (w_is_ram) begin
            bus.RDATA = r_ram[w_ram_idx];
        end else if (bus.ADDR == c_addr_stat) begin
            bus.RDATA = pack_stat(r_rx_full, w_tx_full, w_tx_empty);
        end else if (bus.ADDR == c_addr_rxd) begin
            bus.RDATA = r_rx_data;
        end
    end

    assign bus.STALL    = w_stall;
    assign bus.TX_DATA  = w_tx_dout;
    assign bus.TX_VALID = ~w_tx_empty;
    assign bus.RX_READY = ~r_rx_full;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_io
// Description : Directed self-checking bench for data_mem_io. Define
//               DATA_MEM_CLEAR_EN to exercise the post-reset RAM clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_io;
    import data_mem_io_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_err = 0;

    data_mem_io_if bus();

    data_mem_io dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed=%h required=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic rd(input logic [7:0] a, input string tag, input logic [7:0] exp);
        bus.ADDR = a;
        bus.MW   = 1'b0;
        #1;
        chk(tag, 16'(bus.RDATA), 16'(exp));
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.ADDR  = a;
        bus.WDATA = d;
        bus.MW    = 1'b1;
        tick();
        bus.MW    = 1'b0;
    endtask

    // Count consecutive stalled cycles, bounded so a stuck STALL still ends
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (bus.STALL === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        chk(tag, 16'(n), 16'd128);
    endtask

    initial begin
        RESET        = 1'b1;
        bus.ADDR     = 8'h00;
        bus.WDATA    = 8'h00;
        bus.MW       = 1'b0;
        bus.TX_READY = 1'b0;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        tick();
        tick();
        RESET = 1'b0;

        // Reset state
        chk("rst_txvalid", 16'(bus.TX_VALID), 16'd0);
        chk("rst_rxready", 16'(bus.RX_READY), 16'd1);
`ifdef DATA_MEM_CLEAR_EN
        wait_clear("clear_len_boot");
`else
        chk("rst_stall", 16'(bus.STALL), 16'd0);
`endif
        rd(ADDR_STAT, "rst_stat", 8'h01);

        // RAM store/read, same-cycle read returns old byte
        wr(8'h10, 8'h5A);
        rd(8'h10, "ram_5a", 8'h5A);
        bus.ADDR = 8'h10; bus.WDATA = 8'h33; bus.MW = 1'b1;
        #1;
        chk("ram_old_byte", 16'(bus.RDATA), 16'h5A);
        tick();
        bus.MW = 1'b0;
        rd(8'h10, "ram_new_byte", 8'h33);
        rd(8'h80, "unmapped_80", 8'h00);
        wr(8'h90, 8'h77);
        rd(8'h10, "store_90_ignored", 8'h33);
        rd(ADDR_STAT, "stat_after_90", 8'h01);
        rd(ADDR_TXD, "txd_reads_zero", 8'h00);
        rd(8'hF5, "unmapped_f5", 8'h00);

        // TX fill to full with TX_READY=0
        for (int i = 1; i <= 4; i++) begin
            bus.ADDR = ADDR_TXD; bus.WDATA = 8'(i); bus.MW = 1'b1;
            #1;
            chk("fill_nostall", 16'(bus.STALL), 16'd0);
            tick();
        end
        bus.MW = 1'b0;
        rd(ADDR_STAT, "stat_full", 8'h02);
        chk("full_txdata", 16'(bus.TX_DATA), 16'h01);
        bus.ADDR = ADDR_TXD; bus.WDATA = 8'h05; bus.MW = 1'b1;
        #1;
        chk("stall_5th", 16'(bus.STALL), 16'd1);
        tick();
        chk("stall_hold", 16'(bus.STALL), 16'd1);
        bus.TX_READY = 1'b1;
        #1;
        chk("stall_no_bypass", 16'(bus.STALL), 16'd1);
        tick();
        chk("stall_released", 16'(bus.STALL), 16'd0);
        chk("pop_order_02", 16'(bus.TX_DATA), 16'h02);
        tick();
        bus.MW = 1'b0;
        chk("pop_order_03", 16'(bus.TX_DATA), 16'h03);
        tick();
        chk("pop_order_04", 16'(bus.TX_DATA), 16'h04);
        tick();
        chk("pop_order_05", 16'(bus.TX_DATA), 16'h05);
        tick();
        chk("drained", 16'(bus.TX_VALID), 16'd0);

        // Back-to-back pushes across pointer wrap, TX_READY held high
        for (int i = 0; i < 10; i++) begin
            bus.ADDR = ADDR_TXD; bus.WDATA = 8'hA0 + 8'(i); bus.MW = 1'b1;
            tick();
            chk("wrap_txdata", {8'h00, bus.TX_DATA}, {8'h00, 8'hA0 + 8'(i)});
        end
        bus.MW = 1'b0;
        tick();
        chk("wrap_drained", 16'(bus.TX_VALID), 16'd0);
        bus.TX_READY = 1'b0;

        // RX capture, hold, pop, second capture
        bus.RX_DATA = 8'hC3; bus.RX_VALID = 1'b1;
        #1;
        chk("rx_ready_idle", 16'(bus.RX_READY), 16'd1);
        tick();
        chk("rx_ready_full", 16'(bus.RX_READY), 16'd0);
        rd(ADDR_STAT, "stat_rx_full", 8'h05);
        rd(ADDR_RXD, "rxd_c3", 8'hC3);
        bus.RX_DATA = 8'h3C;
        tick();
        rd(ADDR_RXD, "rxd_held", 8'hC3);
        wr(ADDR_RXD, 8'h00);
        chk("rx_popped", 16'(bus.RX_READY), 16'd1);
        tick();
        chk("rx_second_full", 16'(bus.RX_READY), 16'd0);
        rd(ADDR_RXD, "rxd_3c", 8'h3C);
        bus.RX_VALID = 1'b0;

        // Reset mid-traffic with same-cycle push/pop
        wr(ADDR_TXD, 8'h11);
        wr(ADDR_TXD, 8'h22);
        wr(ADDR_TXD, 8'h33);
        rd(ADDR_STAT, "stat_3_rxfull", 8'h04);
        RESET = 1'b1;
        bus.ADDR = ADDR_TXD; bus.WDATA = 8'h99; bus.MW = 1'b1; bus.TX_READY = 1'b1;
        tick();
        RESET = 1'b0; bus.MW = 1'b0; bus.TX_READY = 1'b0;
        chk("rst2_txvalid", 16'(bus.TX_VALID), 16'd0);
        chk("rst2_rxready", 16'(bus.RX_READY), 16'd1);
`ifdef DATA_MEM_CLEAR_EN
        wait_clear("clear_len_mid_traffic");
`else
        rd(8'h10, "ram_kept_over_reset", 8'h33);
`endif
        rd(ADDR_STAT, "rst2_stat", 8'h01);
        rd(ADDR_RXD, "rst2_rxd", 8'h00);

`ifdef DATA_MEM_CLEAR_EN
        // Clear sweep wipes the top RAM byte
        wr(8'h7F, 8'hFF);
        rd(8'h7F, "ram_7f_ff", 8'hFF);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        wait_clear("clear_len_full");
        rd(8'h7F, "ram_7f_cleared", 8'h00);

        // Reset 50 cycles into a sweep restarts it
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        repeat (50) tick();
        chk("clear_mid_stall", 16'(bus.STALL), 16'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        wait_clear("clear_len_restart");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
